mem_arbiter: RTL and testbench

- Replaces the fake always-grant arbitration between cpu16 and on-chip memory.
- Three requesters share one memory bus, in fixed priority with a starvation guard:
  - debug SPI write port (highest)
  - cpu data read/write port
  - cpu instruction read port
- Drives a single address/data/strobe bus that the top level decodes into sram/vram/ctrl selects.
- Returns registered read data and one-cycle rdy pulses to the cpu.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/prio_grant.sv | 38 +++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and constants for the cpu16 memory arbiter.
//                - gnt_e : which requester owns the memory bus this cycle
//                - tag_e : which read port captures mem_rdata next cycle
//                - SRAM/VRAM/CTRL : address-region codes (addr[15:12]) that
//                  the top level uses to decode the shared bus into selects
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

   localparam int MEM_AW = 16;
   localparam int MEM_DW = 16;

   // Address-region codes, compared against the top nibble of mem_addr
   localparam logic [3:0] SRAM = 4'h0;
   localparam logic [3:0] VRAM = 4'h8;
   localparam logic [3:0] CTRL = 4'hF;

   typedef enum logic [2:0] {
      GNT_NONE = 3'd0,
      GNT_DBG  = 3'd1,
      GNT_DWR  = 3'd2,
      GNT_DRD  = 3'd3,
      GNT_INS  = 3'd4
   } gnt_e;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_INS  = 2'd1,
      TAG_DAT  = 2'd2
   } tag_e;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/prio_grant.sv
`default_nettype none
// ============================================================================
//  Module      : prio_grant
//  Description : Combinational fixed-priority encoder for the memory bus.
//                Order: debug write, starved instruction read, data write,
//                data read, instruction read.
//  Ports       : dbg_req, dwr_req, drd_req, ins_req  request bits
//                ins_starved                         ins has lost too often
//                gnt                                 winning requester
//  Revision    : 1.0  initial release
// ============================================================================
module prio_grant
   import mem_pkg::*;
(
   input  logic dbg_req,
   input  logic dwr_req,
   input  logic drd_req,
   input  logic ins_req,
   input  logic ins_starved,
   output gnt_e gnt
);

   always_comb begin
      gnt = GNT_NONE;
      if (dbg_req)
         gnt = GNT_DBG;
      else if (ins_req && ins_starved)
         gnt = GNT_INS;
      else if (dwr_req)
         gnt = GNT_DWR;
      else if (drd_req)
         gnt = GNT_DRD;
      else if (ins_req)
         gnt = GNT_INS;
   end

endmodule : prio_grant
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates one shared memory bus between the debug SPI write
//                port, the cpu data port and the cpu instruction port.
//                Grant and bus are combinational in cycle N; the matching rdy
//                pulse (and read data) appears in cycle N+1.
//  Ports       : clk, reset_n                  clock, async active-low reset
//                dbg_we/dbg_waddr/dbg_wdata     debug write, never stalled
//                ins_rd_*                       cpu instruction read port
//                dat_rw_addr/dat_rd_*/dat_wr_*  cpu data read/write port
//                mem_addr/mem_wdata/mem_we/mem_re/mem_rdata  shared bus
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int AW             = MEM_AW,
   parameter int DW             = MEM_DW,
   parameter int INS_STARVE_MAX = 4
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_waddr,
   input  logic [DW-1:0] dbg_wdata,
   input  logic          ins_rd_req,
   input  logic [AW-1:0] ins_rd_addr,
   output logic          ins_rd_rdy,
   output logic [DW-1:0] ins_rd_data,
   input  logic [AW-1:0] dat_rw_addr,
   input  logic          dat_rd_req,
   input  logic          dat_wr_req,
   input  logic [DW-1:0] dat_wr_data,
   output logic          dat_rd_rdy,
   output logic [DW-1:0] dat_rd_data,
   output logic          dat_wr_rdy,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic          mem_re,
   input  logic [DW-1:0] mem_rdata
);

   localparam int            CW           = $clog2(INS_STARVE_MAX + 1);
   localparam logic [CW-1:0] C_STARVE_MAX = CW'(INS_STARVE_MAX);

   gnt_e          w_gnt;
   logic          w_ins_starved;
   logic          w_we;
   logic          w_re;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;

   logic [CW-1:0] r_starve_cnt;
   tag_e          r_tag;
   logic          r_ins_rdy;
   logic          r_dat_rd_rdy;
   logic          r_dat_wr_rdy;
   logic [DW-1:0] r_ins_data;
   logic [DW-1:0] r_dat_data;

   assign w_ins_starved = (r_starve_cnt >= C_STARVE_MAX);

   prio_grant u_prio_grant (
      .dbg_req     (dbg_we),
      .dwr_req     (dat_wr_req),
      .drd_req     (dat_rd_req),
      .ins_req     (ins_rd_req),
      .ins_starved (w_ins_starved),
      .gnt         (w_gnt)
   );

   // Shared bus mux; an idle bus drives zeros so the decode sees a quiet bus
   always_comb begin
      w_we    = 1'b0;
      w_re    = 1'b0;
      w_addr  = '0;
      w_wdata = '0;
      case (w_gnt)
         GNT_DBG: begin
            w_we    = 1'b1;
            w_addr  = dbg_waddr;
            w_wdata = dbg_wdata;
         end
         GNT_DWR: begin
            w_we    = 1'b1;
            w_addr  = dat_rw_addr;
            w_wdata = dat_wr_data;
         end
         GNT_DRD: begin
            w_re    = 1'b1;
            w_addr  = dat_rw_addr;
         end
         GNT_INS: begin
            w_re    = 1'b1;
            w_addr  = ins_rd_addr;
         end
         default: ;
      endcase
   end

   assign mem_addr  = w_addr;
   assign mem_wdata = w_wdata;
   // Strobes gated by reset so nothing reaches memory while reset is held
   assign mem_we    = w_we & reset_n;
   assign mem_re    = w_re & reset_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_starve_cnt <= '0;
         r_tag        <= TAG_NONE;
         r_ins_rdy    <= 1'b0;
         r_dat_rd_rdy <= 1'b0;
         r_dat_wr_rdy <= 1'b0;
         r_ins_data   <= '0;
         r_dat_data   <= '0;
      end else begin
         r_ins_rdy    <= (w_gnt == GNT_INS);
         r_dat_rd_rdy <= (w_gnt == GNT_DRD);
         r_dat_wr_rdy <= (w_gnt == GNT_DWR);

         case (w_gnt)
            GNT_INS: r_tag <= TAG_INS;
            GNT_DRD: r_tag <= TAG_DAT;
            default: r_tag <= TAG_NONE;
         endcase

         // Capture the read that is on mem_rdata this cycle so it stays
         // visible after the rdy pulse, until that port's next read
         if (r_tag == TAG_INS)
            r_ins_data <= mem_rdata;
         if (r_tag == TAG_DAT)
            r_dat_data <= mem_rdata;

         if (ins_rd_req && (w_gnt != GNT_INS)) begin
            if (r_starve_cnt != C_STARVE_MAX)
               r_starve_cnt <= r_starve_cnt + 1'b1;
         end else begin
            r_starve_cnt <= '0;
         end
      end
   end

   assign ins_rd_rdy = r_ins_rdy;
   assign dat_rd_rdy = r_dat_rd_rdy;
   assign dat_wr_rdy = r_dat_wr_rdy;

   // mem_rdata arrives in the rdy cycle; pass it straight through then, and
   // serve the held copy afterwards
   assign ins_rd_data = (r_tag == TAG_INS) ? mem_rdata : r_ins_data;
   assign dat_rd_data = (r_tag == TAG_DAT) ? mem_rdata : r_dat_data;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A driver issues
//                requests, evaluates the arbitration rules on its own copy of
//                memory and queues expected bus/rdy/data events; a negedge
//                monitor pops and compares them against the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        dbg_we = 1'b0;
   logic [15:0] dbg_waddr = '0, dbg_wdata = '0;
   logic        ins_rd_req = 1'b0;
   logic [15:0] ins_rd_addr = '0;
   logic        ins_rd_rdy;
   logic [15:0] ins_rd_data;
   logic [15:0] dat_rw_addr = '0;
   logic        dat_rd_req = 1'b0, dat_wr_req = 1'b0;
   logic [15:0] dat_wr_data = '0;
   logic        dat_rd_rdy, dat_wr_rdy;
   logic [15:0] dat_rd_data;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_we, mem_re;
   logic [15:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(16), .DW(16), .INS_STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset_n(reset_n),
      .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
      .ins_rd_req(ins_rd_req), .ins_rd_addr(ins_rd_addr),
      .ins_rd_rdy(ins_rd_rdy), .ins_rd_data(ins_rd_data),
      .dat_rw_addr(dat_rw_addr), .dat_rd_req(dat_rd_req), .dat_wr_req(dat_wr_req),
      .dat_wr_data(dat_wr_data), .dat_rd_rdy(dat_rd_rdy), .dat_rd_data(dat_rd_data),
      .dat_wr_rdy(dat_wr_rdy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata)
   );

   // ---------------- memory device attached to the bus ----------------
   logic [15:0] dev_mem [int];
   logic [15:0] ref_mem [int];

   function automatic logic [15:0] dev_rd(input logic [15:0] a);
      return dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : (a ^ 16'hA5A5);
   endfunction
   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : (a ^ 16'hA5A5);
   endfunction

   always @(posedge clk) begin
      if (mem_we) dev_mem[int'(mem_addr)] = mem_wdata;
      if (mem_re) mem_rdata <= dev_rd(mem_addr);
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- scoreboard ----------------
   typedef struct { int cyc; logic [15:0] data; } rsp_t;
   typedef struct { int cyc; logic we; logic re; logic [15:0] addr; logic [15:0] wdata; } bus_t;
   rsp_t ins_q[$];
   rsp_t drd_q[$];
   int   dwr_q[$];
   bus_t bus_q[$];

   int total = 0, bad = 0;
   bit in_reset = 1'b1;
   logic [15:0] last_ins = '0, last_drd = '0;
   int last_ins_rdy_cyc = -1, last_dwr_rdy_cyc = -1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endfunction

   // ---------------- requester state and reference model ----------------
   bit          ins_pend = 0, drd_pend = 0, dwr_pend = 0;
   logic [15:0] ins_a = '0, dat_a = '0, dat_wd = '0;
   int          starve_m = 0;

   // Present one cycle of stimulus, decide the winner from the priority
   // rules, queue what the DUT must show, then advance to the next cycle.
   task automatic cycle(input bit dbg, input logic [15:0] da, input logic [15:0] dd);
      bus_t b;
      string who;
      bit ins_was_pending;
      dbg_we = dbg; dbg_waddr = da; dbg_wdata = dd;
      ins_rd_req = ins_pend; ins_rd_addr = ins_a;
      dat_rd_req = drd_pend; dat_wr_req = dwr_pend;
      dat_rw_addr = dat_a; dat_wr_data = dat_wd;

      if (dbg)                              who = "dbg";
      else if (ins_pend && starve_m >= SMAX) who = "ins";
      else if (dwr_pend)                    who = "dwr";
      else if (drd_pend)                    who = "drd";
      else if (ins_pend)                    who = "ins";
      else                                  who = "none";

      b.cyc = cyc; b.we = 0; b.re = 0; b.addr = '0; b.wdata = '0;
      ins_was_pending = ins_pend;
      if (who == "dbg") begin
         b.we = 1; b.addr = da; b.wdata = dd;
         ref_mem[int'(da)] = dd;
      end else if (who == "dwr") begin
         b.we = 1; b.addr = dat_a; b.wdata = dat_wd;
         ref_mem[int'(dat_a)] = dat_wd;
         dwr_q.push_back(cyc + 1);
         dwr_pend = 0;
      end else if (who == "drd") begin
         b.re = 1; b.addr = dat_a;
         drd_q.push_back('{cyc + 1, ref_rd(dat_a)});
         drd_pend = 0;
      end else if (who == "ins") begin
         b.re = 1; b.addr = ins_a;
         ins_q.push_back('{cyc + 1, ref_rd(ins_a)});
         ins_pend = 0;
      end
      if (ins_was_pending && who != "ins")
         starve_m = (starve_m + 1 > SMAX) ? SMAX : starve_m + 1;
      else
         starve_m = 0;
      bus_q.push_back(b);
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input int n);
      in_reset = 1'b1;
      reset_n  = 1'b0;
      ins_q.delete(); drd_q.delete(); dwr_q.delete(); bus_q.delete();
      ins_pend = 0; drd_pend = 0; dwr_pend = 0; starve_m = 0;
      last_ins = '0; last_drd = '0;
      dbg_we = 0; ins_rd_req = 0; dat_rd_req = 0; dat_wr_req = 0;
      repeat (n) @(posedge clk);
      #1;
      reset_n  = 1'b1;
      in_reset = 1'b0;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (in_reset) begin
         check("rst_ins_rdy",  {31'b0, ins_rd_rdy}, 0);
         check("rst_drd_rdy",  {31'b0, dat_rd_rdy}, 0);
         check("rst_dwr_rdy",  {31'b0, dat_wr_rdy}, 0);
         check("rst_ins_data", {16'b0, ins_rd_data}, 0);
         check("rst_drd_data", {16'b0, dat_rd_data}, 0);
         check("rst_mem_we",   {31'b0, mem_we}, 0);
         check("rst_mem_re",   {31'b0, mem_re}, 0);
      end else begin
         if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
            bus_t b;
            b = bus_q.pop_front();
            check("bus_we",   {31'b0, mem_we}, {31'b0, b.we});
            check("bus_re",   {31'b0, mem_re}, {31'b0, b.re});
            check("bus_addr", {16'b0, mem_addr}, {16'b0, b.addr});
            if (b.we || !b.re)
               check("bus_wdata", {16'b0, mem_wdata}, {16'b0, b.wdata});
         end

         if (ins_q.size() > 0 && ins_q[0].cyc == cyc) begin
            rsp_t r;
            r = ins_q.pop_front();
            check("ins_rdy", {31'b0, ins_rd_rdy}, 1);
            check("ins_data", {16'b0, ins_rd_data}, {16'b0, r.data});
            last_ins = r.data;
            last_ins_rdy_cyc = cyc;
         end else begin
            check("ins_rdy", {31'b0, ins_rd_rdy}, 0);
            check("ins_hold", {16'b0, ins_rd_data}, {16'b0, last_ins});
         end

         if (drd_q.size() > 0 && drd_q[0].cyc == cyc) begin
            rsp_t r;
            r = drd_q.pop_front();
            check("drd_rdy", {31'b0, dat_rd_rdy}, 1);
            check("drd_data", {16'b0, dat_rd_data}, {16'b0, r.data});
            last_drd = r.data;
         end else begin
            check("drd_rdy", {31'b0, dat_rd_rdy}, 0);
            check("drd_hold", {16'b0, dat_rd_data}, {16'b0, last_drd});
         end

         if (dwr_q.size() > 0 && dwr_q[0] == cyc) begin
            void'(dwr_q.pop_front());
            check("dwr_rdy", {31'b0, dat_wr_rdy}, 1);
            last_dwr_rdy_cyc = cyc;
         end else begin
            check("dwr_rdy", {31'b0, dat_wr_rdy}, 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [3:0] regions [3] = '{4'h0, 4'h8, 4'hF};

   function automatic logic [15:0] rand_addr();
      return {regions[$urandom_range(2)], 12'($urandom_range(23))};
   endfunction

   initial begin
      int t0;
      #2;
      do_reset(3);

      // back-to-back instruction reads
      for (int i = 0; i < 4; i++) begin
         ins_pend = 1; ins_a = 16'h0010 + 16'(i);
         cycle(0, '0, '0);
      end
      repeat (2) cycle(0, '0, '0);
      check("ins_seq_last", {16'b0, ins_rd_data}, 32'h0000A5B6);

      // debug write collides with a data write
      dwr_pend = 1; dat_a = 16'h0020; dat_wd = 16'h1234;
      t0 = cyc;
      cycle(1, 16'h8004, 16'h0041);
      repeat (2) cycle(0, '0, '0);
      check("dwr_after_dbg_cyc", 32'(last_dwr_rdy_cyc), 32'(t0 + 2));
      check("mem_8004", {16'b0, dev_rd(16'h8004)}, 32'h00000041);
      check("mem_0020", {16'b0, dev_rd(16'h0020)}, 32'h00001234);

      // instruction starvation guard against a streaming data read
      ins_pend = 1; ins_a = 16'h0040;
      t0 = cyc;
      for (int i = 0; i < 10; i++) begin
         drd_pend = 1; dat_a = 16'h0100 + 16'(i);
         cycle(0, '0, '0);
      end
      repeat (2) cycle(0, '0, '0);
      check("starve_ins_rdy_cyc", 32'(last_ins_rdy_cyc), 32'(t0 + 5));

      // simultaneous data write and read to the same address
      drd_pend = 1; dwr_pend = 1; dat_a = 16'h0030; dat_wd = 16'hBEEF;
      repeat (4) cycle(0, '0, '0);
      check("rw_same_addr", {16'b0, dat_rd_data}, 32'h0000BEEF);

      // reset in the cycle after an instruction grant
      ins_pend = 1; ins_a = 16'h0050;
      cycle(0, '0, '0);
      do_reset(2);
      ins_pend = 1; ins_a = 16'h0051;
      repeat (3) cycle(0, '0, '0);
      check("post_reset_ins", {16'b0, ins_rd_data}, 32'h0000A5F4);

      // idle bus
      repeat (4) cycle(0, '0, '0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if (!ins_pend && $urandom_range(1) == 1) begin
            ins_pend = 1; ins_a = rand_addr();
         end
         if (!drd_pend && !dwr_pend && $urandom_range(1) == 1) begin
            int k;
            k = $urandom_range(2);
            dat_a  = rand_addr();
            dat_wd = 16'($urandom);
            drd_pend = (k != 1);
            dwr_pend = (k != 0);
         end
         cycle($urandom_range(4) == 0, rand_addr(), 16'($urandom));
      end
      repeat (10) cycle(0, '0, '0);
      check("drain", 32'(ins_q.size() + drd_q.size() + dwr_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mem_arbiter
`default_nettype wire
